seg7_scan_ctrl: RTL and testbench
=================================

Name: seg7_scan_ctrl

Overview:
- Time-multiplexed controller for a common-anode multi-digit 7-segment display.
- Holds one committed hex nibble and one decimal-point bit per digit.
- Scans one digit at a time through a single hex-to-segment decoder instance, with anti-ghosting blanking and optional leading-zero suppression.
- Accepts frame updates from the core over a valid/ready write port. Updates commit only at frame boundaries, so the display never tears.

Parameters:
- NUM_DIGITS, 8, number of digits scanned (2..16).
- SCAN_DIV, 50000, clock cycles per digit slot (>= 2).
- BLANK_CYC, 2, cycles at the start of each slot with all anodes off (0 <= BLANK_CYC < SCAN_DIV).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- wr_valid  in  1  write request.
- wr_ready  out  1  controller can accept a write.
- wr_data  in  4*NUM_DIGITS  nibble i = digit i (digit 0 is rightmost).
- wr_dp  in  NUM_DIGITS  decimal-point value per digit.
- wr_mask  in  NUM_DIGITS  1 = update digit i (nibble and dp).
- lz_blank  in  1  leading-zero suppression enable (level, sampled every cycle).
- seg_n  out  7  segments {g..a}, active-low.
- dp_n  out  1  decimal point, active-low.
- an_n  out  NUM_DIGITS  digit anodes, active-low, at most one low.
- frame_done  out  1  one-cycle pulse after the last digit slot ends.

Behaviour:
- Reset values (synchronous, while rst_n=0):
  - seg_n=7'h7F, dp_n=1, an_n=all 1s, frame_done=0, wr_ready=1.
  - Committed digits=0, dp=0, pending buffer empty, slot index=0, prescaler=0.
  - Reset asserted mid-write or mid-frame discards any pending write.
- Prescaler:
  - Counts 0..SCAN_DIV-1. At count SCAN_DIV-1 ("tick") it wraps to 0 and the index advances.
  - The index wraps NUM_DIGITS-1 -> 0.
- Registered outputs (one-cycle latency from internal state):
  - While prescaler < BLANK_CYC: an_n=all 1s, seg_n=7'h7F, dp_n=1.
  - Otherwise: an_n = ~(1<<index), seg_n = decode(committed[index]), dp_n = ~dp[index].
- Write handshake:
  - Transfer happens on a cycle with wr_valid & wr_ready. wr_data, wr_dp and wr_mask are latched into the pending buffer and wr_ready drops the next cycle.
  - wr_ready = pending buffer empty. wr_valid may be held; no combinational path from wr_valid to wr_ready.
- Commit:
  - Frame end = tick with index==NUM_DIGITS-1.
  - At frame end with pending valid: for each i with mask[i]=1, committed nibble/dp[i] take the pending values. Pending clears, so wr_ready=1 next cycle.
  - Mask all-zero is accepted and commits no change.
- Simultaneous transfer and frame end: the new write goes into pending and commits at the next frame end, not this one.
- frame_done: registered, high the cycle after every frame end, whether or not a commit occurred.
- Leading-zero suppression (lz_blank=1):
  - Digit i (i>0) shows seg_n=7'h7F when committed[j]==0 for all j>=i. dp_n is unaffected.
  - Digit 0 is never suppressed. The anode still asserts for suppressed digits.
- Arithmetic:
  - Prescaler width = $clog2(SCAN_DIV); index width = $clog2(NUM_DIGITS).
  - No other arithmetic.

Decomposition:
- Package seg7_pkg:
  - SEG_BLANK = 7'h7F.
  - Default values for NUM_DIGITS, SCAN_DIV and BLANK_CYC.
  - Helper function for the leading-zero mask.
- One sub-module instance: hex_display (4-bit src -> 7-bit segment), fed by the muxed committed nibble.
- The scan/commit logic stays in seg7_scan_ctrl.

Test Plan (NUM_DIGITS=4, SCAN_DIV=4, BLANK_CYC=1 unless noted):
- Reset, no writes -> frame_done every 16 cycles. Slots show an_n 1110, 1101, 1011, 0111, each preceded by one all-1s cycle. seg_n=7'h40 ("0") when lit.
- Write wr_data=16'h1234, mask=4'hF, dp=4'b0001 mid-frame -> wr_ready low until the cycle after the next frame end. Next frame digit0 seg_n=7'h19 ("4") with dp_n=0, digit3 seg_n=7'h79 ("1").
- Second write held valid while pending -> not accepted. After commit, wr_ready=1, transfer occurs, and it commits one frame later.
- Committed 16'h0070 with lz_blank=1 -> digits 3 and 2 seg_n=7'h7F, digit1 seg_n=7'h78 ("7"), digit0 seg_n=7'h40 ("0"). With lz_blank=0, all four digits are lit.
- Write with mask=4'b0100, data=16'hFFFF over 16'h1234 -> committed becomes 16'h1F34.
- rst_n low for one cycle mid-slot with a write pending -> next cycle all outputs at reset values, wr_ready=1, digits 0. The old pending write never appears.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the 7-segment scan controller.
// Holds blank pattern, parameter defaults and the leading-zero mask helper.
package seg7_pkg;

  localparam int DEF_DIGITS   = 8;
  localparam int DEF_SCAN_DIV = 50000;
  localparam int DEF_BLANK    = 2;
  localparam int MAX_DIGITS   = 16;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Bit i set when digit i (i>0) and every digit above it are zero.
  // nib is packed digit-0-first; digits at or above n are ignored.
  function automatic logic [MAX_DIGITS-1:0] lz_mask(
    input logic [4*MAX_DIGITS-1:0] nib,
    input int                      n
  );
    logic [MAX_DIGITS-1:0] m;
    logic                  z;
    m = '0;
    z = 1'b1;
    for (int i = MAX_DIGITS - 1; i > 0; i--) begin
      if (i < n) begin
        z    = z & (nib[i*4 +: 4] == 4'h0);
        m[i] = z;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_hex.sv
// Hex nibble to 7-segment pattern, active-low, bit order {g..a}.
// Ports: src (4-bit nibble in), seg (7-bit segment pattern out).
module hex_display
  import seg7_pkg::*;
(
  input  logic [3:0] src,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    unique case (src)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode 7-segment scanner with tear-free frame updates.
// Ports: clk, rst_n (sync, low), wr_* write port, lz_blank, seg_n/dp_n/an_n, frame_done.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = DEF_DIGITS,
  parameter int SCAN_DIV   = DEF_SCAN_DIV,
  parameter int BLANK_CYC  = DEF_BLANK
)(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [4*NUM_DIGITS-1:0] wr_data,
  input  logic [NUM_DIGITS-1:0]   wr_dp,
  input  logic [NUM_DIGITS-1:0]   wr_mask,
  input  logic                    lz_blank,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);

  localparam logic [PW-1:0] CNT_TOP = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_TOP = IW'(NUM_DIGITS - 1);

  logic [PW-1:0] cnt;
  logic [IW-1:0] idx;

  logic [NUM_DIGITS-1:0][3:0] dig;
  logic [NUM_DIGITS-1:0]      dpr;

  logic                       pv;
  logic [NUM_DIGITS-1:0][3:0] pdat;
  logic [NUM_DIGITS-1:0]      pdp;
  logic [NUM_DIGITS-1:0]      pmask;

  logic            tick;
  logic            fend;
  logic            xfer;
  logic            blank;
  logic            supp;
  logic [3:0]      nib;
  logic [6:0]      seg;
  logic [MAX_DIGITS-1:0] lzm;

  assign tick     = (cnt == CNT_TOP);
  assign fend     = tick & (idx == IDX_TOP);
  assign wr_ready = ~pv;
  assign xfer     = wr_valid & ~pv;

  if (BLANK_CYC == 0) begin : g_noblank
    assign blank = 1'b0;
  end else begin : g_blank
    assign blank = (cnt < PW'(BLANK_CYC));
  end

  assign nib  = dig[idx];
  assign lzm  = lz_mask((4*MAX_DIGITS)'(dig), NUM_DIGITS);
  assign supp = lz_blank & lzm[4'(idx)];

  hex_display u_hex (
    .src (nib),
    .seg (seg)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      dig        <= '0;
      dpr        <= '0;
      pv         <= 1'b0;
      pdat       <= '0;
      pdp        <= '0;
      pmask      <= '0;
      seg_n      <= SEG_BLANK;
      dp_n       <= 1'b1;
      an_n       <= '1;
      frame_done <= 1'b0;
    end else begin
      cnt        <= tick ? '0 : cnt + 1'b1;
      frame_done <= fend;
      if (tick) begin
        idx <= (idx == IDX_TOP) ? '0 : idx + 1'b1;
      end
      // Pending can only be full or loading, never both, so a
      // write landing on a frame end waits for the next one.
      if (fend && pv) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (pmask[i]) begin
            dig[i] <= pdat[i];
            dpr[i] <= pdp[i];
          end
        end
        pv <= 1'b0;
      end
      if (xfer) begin
        pv    <= 1'b1;
        pdat  <= wr_data;
        pdp   <= wr_dp;
        pmask <= wr_mask;
      end
      if (blank) begin
        an_n  <= '1;
        seg_n <= SEG_BLANK;
        dp_n  <= 1'b1;
      end else begin
        an_n  <= ~(NUM_DIGITS'(1) << idx);
        seg_n <= supp ? SEG_BLANK : seg;
        dp_n  <= ~dpr[idx];
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl (4 digits, 4-cycle slots, 1 blank).
// Accepted writes push the expected frame image; a monitor checks every cycle.
module tb_seg7_scan_ctrl;

  localparam int N  = 4;
  localparam int SD = 4;
  localparam int BC = 1;
  localparam int FR = N * SD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [15:0] wr_data = '0;
  logic [3:0]  wr_dp = '0;
  logic [3:0]  wr_mask = '0;
  logic        lz_blank = 1'b0;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        frame_done;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .NUM_DIGITS (N),
    .SCAN_DIV   (SD),
    .BLANK_CYC  (BC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .wr_dp      (wr_dp),
    .wr_mask    (wr_mask),
    .lz_blank   (lz_blank),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .an_n       (an_n),
    .frame_done (frame_done)
  );

  typedef struct {
    int          f;
    logic [15:0] img;
    logic [3:0]  dp;
  } exp_t;

  exp_t q[$];

  int errs = 0;
  int checks = 0;
  int n = 0;
  int pend_fe = -1;
  int acc_cnt = 0;
  bit started = 1'b0;
  bit lz_hist = 1'b0;

  logic [15:0] model_img = '0;
  logic [3:0]  model_dp = '0;
  logic [15:0] cur = '0;
  logic [3:0]  cur_dp = '0;

  logic [6:0] segtab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, n);
    end
  endtask

  // Reference model: state cycle n since reset; writes commit at the
  // first frame end strictly after the accepting cycle.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        n         = 0;
        pend_fe   = -1;
        model_img = '0;
        model_dp  = '0;
        started   = 1'b1;
        q.delete();
      end else begin
        bit   rdy;
        exp_t e;
        rdy = (pend_fe < 0);
        if (pend_fe == n) pend_fe = -1;
        if (wr_valid && rdy) begin
          for (int i = 0; i < N; i++) begin
            if (wr_mask[i]) begin
              model_img[i*4 +: 4] = wr_data[i*4 +: 4];
              model_dp[i]         = wr_dp[i];
            end
          end
          e.f     = (n + 1) / FR + 1;
          e.img   = model_img;
          e.dp    = model_dp;
          pend_fe = e.f * FR - 1;
          q.push_back(e);
          acc_cnt++;
        end
        lz_hist = lz_blank;
        n++;
      end
    end
  end

  // Monitor: outputs seen in cycle n reflect state cycle n-1.
  initial begin
    forever begin
      @(negedge clk);
      if (!started) continue;
      if (n == 0) begin
        cur    = '0;
        cur_dp = '0;
        chk("rst_seg", 32'(seg_n), 32'h7F);
        chk("rst_dp", 32'(dp_n), 32'h1);
        chk("rst_an", 32'(an_n), 32'hF);
        chk("rst_fd", 32'(frame_done), 32'h0);
        chk("rst_rdy", 32'(wr_ready), 32'h1);
      end else begin
        int         m;
        int         d;
        bit         sup;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        m = n - 1;
        if (m > 0 && m % FR == 0) begin
          if (q.size() > 0 && q[0].f == m / FR) begin
            cur    = q[0].img;
            cur_dp = q[0].dp;
            void'(q.pop_front());
          end
        end
        d = (m / SD) % N;
        if (m % SD < BC) begin
          e_an  = 4'hF;
          e_seg = 7'h7F;
          e_dp  = 1'b1;
        end else begin
          sup   = lz_hist && d > 0 && ((cur >> (d * 4)) == 16'h0);
          e_an  = ~(4'b0001 << d);
          e_seg = sup ? 7'h7F : segtab[cur[d*4 +: 4]];
          e_dp  = ~cur_dp[d];
        end
        chk("an_n", 32'(an_n), 32'(e_an));
        chk("seg_n", 32'(seg_n), 32'(e_seg));
        chk("dp_n", 32'(dp_n), 32'(e_dp));
        chk("frame_done", 32'(frame_done), 32'(n % FR == 0));
        chk("wr_ready", 32'(wr_ready), 32'(pend_fe < 0));
      end
    end
  end

  task automatic wr(logic [15:0] d, logic [3:0] p, logic [3:0] mk);
    int a0;
    bit ok;
    a0       = acc_cnt;
    ok       = 1'b0;
    wr_data  = d;
    wr_dp    = p;
    wr_mask  = mk;
    wr_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (acc_cnt != a0) begin
        ok = 1'b1;
        break;
      end
    end
    wr_valid = 1'b0;
    if (!ok) begin
      checks++;
      errs++;
      $display("FAIL wr_accept: no transfer of %h within 200 cycles", d);
    end
  endtask

  task automatic idle(int c);
    repeat (c) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(40);
    idle(5);
    wr(16'h1234, 4'b0001, 4'hF);
    wr(16'hFFFF, 4'b0000, 4'b0100);
    idle(40);
    wr(16'h0070, 4'b0000, 4'hF);
    idle(20);
    lz_blank = 1'b1;
    idle(40);
    lz_blank = 1'b0;
    idle(20);
    wr(16'hAAAA, 4'hF, 4'h0);
    idle(40);
    for (int i = 0; i < FR && n % FR != 2; i++) idle(1);
    wr(16'h9999, 4'hF, 4'hF);
    idle(3);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(40);
    for (int k = 0; k < 24; k++) begin
      logic [15:0] d;
      d = 16'($urandom);
      if ($urandom_range(0, 2) == 0) d = d & 16'h00FF;
      lz_blank = 1'($urandom_range(0, 1));
      wr(d, 4'($urandom), 4'($urandom));
      idle($urandom_range(0, 30));
    end
    idle(40);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
